// File: rtl/tiny_risc_pkg.sv
// tiny_risc_pkg: state, opcode and ALU-function encodings shared by the controller, datapath and bench
package tiny_risc_pkg;
  typedef enum logic [3:0] {S_RST, S_F1, S_F2, S_DEC, S_RD, S_EX, S_WR, S_JMP, S_HALT} state_t;
  typedef enum logic [1:0] {ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND} alu_sel_t;
  localparam logic [2:0] OP_LDA = 3'b000, OP_STA = 3'b001, OP_ADD = 3'b010, OP_JMP = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100, OP_AND = 3'b101, OP_JZ = 3'b110, OP_HLT = 3'b111;
  localparam logic [3:0] FN_PASS = 4'b1000, FN_ADD = 4'b0100, FN_SUB = 4'b0010, FN_AND = 4'b0001;
  typedef struct packed {
    logic rd_mem, wr_mem, ir_on_adr, pc_on_adr, dbus_on_data, data_on_dbus;
    logic ld_ir, ld_ac, ld_pc, inc_pc, clr_pc;
    logic pass, add, sub, and_op, alu_on_dbus, halted;
  } ctrl_t;
  function automatic alu_sel_t alu_sel(logic [2:0] op);
    return op == OP_ADD ? ALU_ADD : op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : ALU_PASS;
  endfunction
  function automatic logic [3:0] alu_fn(alu_sel_t a);
    return a == ALU_ADD ? FN_ADD : a == ALU_SUB ? FN_SUB : a == ALU_AND ? FN_AND : FN_PASS;
  endfunction
  function automatic state_t dec_next(logic [2:0] op, logic ac_zero);
    return (op == OP_LDA || op == OP_ADD || op == OP_SUB || op == OP_AND) ? S_RD :
           op == OP_STA ? S_WR : op == OP_JMP ? S_JMP :
           op == OP_JZ ? (ac_zero ? S_JMP : S_F1) : S_HALT;
  endfunction
  function automatic ctrl_t decode(state_t s, alu_sel_t a);
    ctrl_t c;
    c = '0;
    case (s)
      S_RST: c.clr_pc = 1'b1;
      S_F1: {c.pc_on_adr, c.rd_mem} = 2'b11;
      S_F2: {c.pc_on_adr, c.rd_mem, c.data_on_dbus, c.ld_ir, c.inc_pc} = 5'b11111;
      S_DEC: c.ir_on_adr = 1'b1;
      S_RD: {c.ir_on_adr, c.rd_mem} = 2'b11;
      S_EX: begin
        {c.ir_on_adr, c.rd_mem, c.data_on_dbus, c.ld_ac} = 4'b1111;
        {c.pass, c.add, c.sub, c.and_op} = alu_fn(a);
      end
      S_WR: {c.ir_on_adr, c.pass, c.alu_on_dbus, c.dbus_on_data, c.wr_mem} = 5'b11111;
      S_JMP: {c.ir_on_adr, c.ld_pc} = 2'b11;
      default: c.halted = 1'b1;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/tiny_risc_controller_if.sv
// tiny_risc_controller_if: opcode/status inputs and datapath/memory strobes of the control unit
interface tiny_risc_controller_if #(parameter int OPC_W = 3);
  logic [OPC_W-1:0] op_code;
  logic mem_rdy, ac_zero;
  logic rd_mem, wr_mem, ir_on_adr, pc_on_adr, dbus_on_data, data_on_dbus;
  logic ld_ir, ld_ac, ld_pc, inc_pc, clr_pc;
  logic pass, add, sub, and_op, alu_on_dbus;
  logic instr_done, halted, bus_err, ill_op;
  modport master (
    input op_code, mem_rdy, ac_zero,
    output rd_mem, wr_mem, ir_on_adr, pc_on_adr, dbus_on_data, data_on_dbus,
    output ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass, add, sub, and_op, alu_on_dbus,
    output instr_done, halted, bus_err, ill_op
  );
  modport slave (
    output op_code, mem_rdy, ac_zero,
    input rd_mem, wr_mem, ir_on_adr, pc_on_adr, dbus_on_data, data_on_dbus,
    input ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass, add, sub, and_op, alu_on_dbus,
    input instr_done, halted, bus_err, ill_op
  );
endinterface

// File: rtl/tiny_risc_wait_timer.sv
// tiny_risc_wait_timer: counts consecutive memory wait cycles and flags the bus timeout
module tiny_risc_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  output logic timeout
);
  localparam int CW = WAIT_MAX > 0 ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX);
  logic [CW-1:0] cnt;
  // Any cycle without a stall (ready, or outside a wait state) restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else cnt <= !waiting ? '0 : cnt == LIMIT ? cnt : cnt + 1'b1;
  end
  assign timeout = WAIT_MAX > 0 && waiting && cnt == LIMIT;
endmodule

// File: rtl/tiny_risc_controller.sv
// tiny_risc_controller: Moore FSM sequencing fetch/decode/execute with wait states, timeout and traps
module tiny_risc_controller
  import tiny_risc_pkg::*;
#(
  parameter int OPC_W        = 3,
  parameter int WAIT_MAX     = 15,
  parameter int RESET_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  tiny_risc_controller_if.master bus
);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  state_t state, state_nx;
  alu_sel_t op_q;
  ctrl_t ctl;
  logic [RW-1:0] rst_cnt;
  logic waiting, timeout, ill, done_q, err_q, ill_q;
  assign waiting = (state == S_F1 || state == S_RD || state == S_WR) && !bus.mem_rdy;
  assign ill = (bus.op_code >> 3) != '0;
  tiny_risc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk(clk),
    .reset(reset),
    .waiting(waiting),
    .timeout(timeout)
  );
  always_comb begin
    state_nx = state;
    case (state)
      S_RST: state_nx = rst_cnt == RW'(RESET_CYCLES - 1) ? S_F1 : S_RST;
      S_F1: state_nx = bus.mem_rdy ? S_F2 : timeout ? S_HALT : S_F1;
      S_F2: state_nx = S_DEC;
      S_DEC: state_nx = ill ? S_HALT : dec_next(bus.op_code[2:0], bus.ac_zero);
      S_RD: state_nx = bus.mem_rdy ? S_EX : timeout ? S_HALT : S_RD;
      S_EX, S_JMP: state_nx = S_F1;
      S_WR: state_nx = bus.mem_rdy ? S_F1 : timeout ? S_HALT : S_WR;
      default: state_nx = S_HALT;
    endcase
  end
  // Strobes are decoded from the next state so they register alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_RST;
      rst_cnt <= '0;
      op_q <= ALU_PASS;
      ctl <= decode(S_RST, ALU_PASS);
      done_q <= 1'b0;
      err_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state <= state_nx;
      rst_cnt <= state == S_RST ? rst_cnt + 1'b1 : '0;
      op_q <= state == S_DEC ? alu_sel(bus.op_code[2:0]) : op_q;
      ctl <= decode(state_nx, op_q);
      done_q <= state_nx == S_F1 && state inside {S_DEC, S_EX, S_WR, S_JMP};
      err_q <= err_q | timeout;
      ill_q <= ill_q | (state == S_DEC && ill);
    end
  end
  assign {bus.rd_mem, bus.wr_mem, bus.ir_on_adr, bus.pc_on_adr, bus.dbus_on_data, bus.data_on_dbus,
          bus.ld_ir, bus.ld_ac, bus.ld_pc, bus.inc_pc, bus.clr_pc,
          bus.pass, bus.add, bus.sub, bus.and_op, bus.alu_on_dbus, bus.halted} = ctl;
  assign bus.instr_done = done_q;
  assign bus.bus_err = err_q;
  assign bus.ill_op = ill_q;
endmodule

// File: tb/tb_tiny_risc_controller.sv
// tb_tiny_risc_controller: directed table-driven checks of the Tiny RISC control FSM
module tb_tiny_risc_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic armed = 1'b0;
  int tests = 0;
  int fails = 0;
  // strobe order: rd wr ir pc dbus_on_data data_on_dbus ld_ir ld_ac ld_pc inc clr pass add sub and alu_on_dbus halted
  localparam logic [16:0] V_RST  = 17'b0_0_0_0_0_0_0_0_0_0_1_0_0_0_0_0_0;
  localparam logic [16:0] V_F1   = 17'b1_0_0_1_0_0_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] V_F2   = 17'b1_0_0_1_0_1_1_0_0_1_0_0_0_0_0_0_0;
  localparam logic [16:0] V_DEC  = 17'b0_0_1_0_0_0_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] V_WR   = 17'b0_1_1_0_1_0_0_0_0_0_0_1_0_0_0_1_0;
  localparam logic [16:0] V_JMP  = 17'b0_0_1_0_0_0_0_0_1_0_0_0_0_0_0_0_0;
  localparam logic [16:0] V_EXP  = 17'b1_0_1_0_0_1_0_1_0_0_0_1_0_0_0_0_0;
  localparam logic [16:0] V_EXA  = 17'b1_0_1_0_0_1_0_1_0_0_0_0_1_0_0_0_0;
  localparam logic [16:0] V_EXS  = 17'b1_0_1_0_0_1_0_1_0_0_0_0_0_1_0_0_0;
  localparam logic [16:0] V_EXN  = 17'b1_0_1_0_0_1_0_1_0_0_0_0_0_0_1_0_0;
  localparam logic [16:0] V_HALT = 17'b0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_1;

  typedef struct {
    string name;
    logic [3:0] op;
    logic az;
    int len;
    logic [16:0] last;
  } vec_t;

  tiny_risc_controller_if #(.OPC_W(4)) bus ();
  tiny_risc_controller #(.OPC_W(4), .WAIT_MAX(15), .RESET_CYCLES(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] snap();
    return {bus.rd_mem, bus.wr_mem, bus.ir_on_adr, bus.pc_on_adr, bus.dbus_on_data, bus.data_on_dbus,
            bus.ld_ir, bus.ld_ac, bus.ld_pc, bus.inc_pc, bus.clr_pc,
            bus.pass, bus.add, bus.sub, bus.and_op, bus.alu_on_dbus, bus.halted};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    int c;
    @(negedge clk);
    reset = 1'b0;
    bus.mem_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset strobes", 32'(snap()), 32'(V_RST));
    chk("reset bus_err", 32'(bus.bus_err), 0);
    chk("reset ill_op", 32'(bus.ill_op), 0);
    chk("reset instr_done", 32'(bus.instr_done), 0);
    reset = 1'b1;
    c = 0;
    while (bus.clr_pc && c < 10) begin
      c++;
      @(negedge clk);
    end
    chk("clr_pc cycles", 32'(c), 2);
    chk("first fetch", 32'(snap()), 32'(V_F1));
    chk("first fetch done", 32'(bus.instr_done), 0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.instr_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.instr_done), 1);
  endtask

  // Bus-level exclusivity must hold on every cycle out of reset.
  always @(negedge clk) begin
    if (armed && reset) begin
      tests++;
      if ((bus.rd_mem && bus.wr_mem) || (bus.ir_on_adr && bus.pc_on_adr) ||
          $countones({bus.pass, bus.add, bus.sub, bus.and_op}) > 1) begin
        fails++;
        $display("FAIL exclusivity: rd/wr=%b%b ir/pc=%b%b fn=%b, required no overlap",
                 bus.rd_mem, bus.wr_mem, bus.ir_on_adr, bus.pc_on_adr,
                 {bus.pass, bus.add, bus.sub, bus.and_op});
      end
    end
  end

  initial begin
    vec_t vecs [8];
    logic [16:0] prev;
    int n, c;
    vecs[0] = '{"LDA", 4'b0000, 1'b0, 5, V_EXP};
    vecs[1] = '{"ADD", 4'b0010, 1'b0, 5, V_EXA};
    vecs[2] = '{"SUB", 4'b0100, 1'b1, 5, V_EXS};
    vecs[3] = '{"AND", 4'b0101, 1'b0, 5, V_EXN};
    vecs[4] = '{"STA", 4'b0001, 1'b0, 4, V_WR};
    vecs[5] = '{"JMP", 4'b0011, 1'b0, 4, V_JMP};
    vecs[6] = '{"JZ taken", 4'b0110, 1'b1, 4, V_JMP};
    vecs[7] = '{"JZ untaken", 4'b0110, 1'b0, 3, V_DEC};
    bus.op_code = '0;
    bus.ac_zero = 1'b0;
    bus.mem_rdy = 1'b1;
    #1 reset = 1'b0;
    do_reset();
    armed = 1'b1;

    foreach (vecs[k]) begin
      bus.op_code = vecs[k].op;
      bus.ac_zero = vecs[k].az;
      bus.mem_rdy = 1'b1;
      @(negedge clk);
      n = 1;
      chk({vecs[k].name, " F2"}, 32'(snap()), 32'(V_F2));
      chk({vecs[k].name, " done low"}, 32'(bus.instr_done), 0);
      prev = '0;
      while (!bus.instr_done && n < 20) begin
        prev = snap();
        @(negedge clk);
        n++;
      end
      chk({vecs[k].name, " len"}, 32'(n), 32'(vecs[k].len));
      chk({vecs[k].name, " last"}, 32'(prev), 32'(vecs[k].last));
      chk({vecs[k].name, " refetch"}, 32'(snap()), 32'(V_F1));
    end

    // STA stalled 4 cycles in the write state
    bus.op_code = 4'b0001;
    bus.mem_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.mem_rdy = 1'b0;
    c = 0;
    for (int i = 0; i < 20 && !bus.instr_done; i++) begin
      @(negedge clk);
      if (bus.wr_mem) begin
        c++;
        if (c == 5) bus.mem_rdy = 1'b1;
      end
    end
    chk("STA wait wr cycles", 32'(c), 5);
    chk("STA wait done", 32'(bus.instr_done), 1);
    chk("STA wait bus_err", 32'(bus.bus_err), 0);

    // ready arriving exactly at the wait limit completes the fetch
    bus.op_code = 4'b0011;
    bus.mem_rdy = 1'b0;
    repeat (15) @(negedge clk);
    chk("limit-1 still fetching", 32'(snap()), 32'(V_F1));
    bus.mem_rdy = 1'b1;
    @(negedge clk);
    chk("limit ready wins", 32'(snap()), 32'(V_F2));
    chk("limit no bus_err", 32'(bus.bus_err), 0);
    wait_done("JMP after limit");

    // asynchronous reset mid-write
    bus.op_code = 4'b0001;
    bus.mem_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.mem_rdy = 1'b0;
    @(negedge clk);
    chk("mid-write strobes", 32'(snap()), 32'(V_WR));
    #2 reset = 1'b0;
    #1 chk("async reset mid-write", 32'(snap()), 32'(V_RST));
    do_reset();

    // memory stuck not-ready in fetch
    bus.mem_rdy = 1'b0;
    n = 0;
    while (!bus.halted && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout cycles", 32'(n), 16);
    chk("timeout bus_err", 32'(bus.bus_err), 1);
    chk("timeout ill_op", 32'(bus.ill_op), 0);
    bus.mem_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("halt holds", 32'(snap()), 32'(V_HALT));
    chk("bus_err sticky", 32'(bus.bus_err), 1);
    #2 reset = 1'b0;
    #1 chk("reset clears bus_err", 32'(bus.bus_err), 0);
    do_reset();

    // illegal opcode trap, then a legal HLT
    bus.op_code = 4'b1010;
    n = 0;
    while (!bus.halted && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("illegal halt cycles", 32'(n), 3);
    chk("illegal ill_op", 32'(bus.ill_op), 1);
    chk("illegal bus_err", 32'(bus.bus_err), 0);
    do_reset();
    bus.op_code = 4'b0111;
    n = 0;
    while (!bus.halted && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("HLT halt cycles", 32'(n), 3);
    chk("HLT strobes", 32'(snap()), 32'(V_HALT));
    chk("HLT ill_op", 32'(bus.ill_op), 0);

    armed = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
